// File: rtl/theta_phase_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : theta_phase_accumulator
//  Brief    : Per-step Q3.28 angle integrator with [-pi, pi) wrap and a cosine
//             stage start/done handshake guarded by a watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module theta_phase_accumulator #(
    parameter int                    W        = 32,
    parameter logic signed [W-1:0]   PI_Q     = 32'sd843314857,
    parameter logic signed [W-1:0]   TWO_PI_Q = 32'sd1686629713,
    parameter int                    TIMEOUT  = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    input  logic         load,
    input  logic [W-1:0] theta_init,
    input  logic [W-1:0] omega_dt,
    input  logic         clr_err,
    input  logic         cos_done,
    output logic [W-1:0] theta,
    output logic         sta_cos,
    output logic         busy,
    output logic         done_sig,
    output logic         err_overrun,
    output logic         err_timeout
);

    localparam int c_CNT_W = $clog2(TIMEOUT);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ACCUM = 3'd1;
    localparam logic [2:0] c_WRAP  = 3'd2;
    localparam logic [2:0] c_ISSUE = 3'd3;
    localparam logic [2:0] c_WAIT  = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    localparam logic signed [W-1:0] c_PI_M1     = PI_Q - W'(1);
    localparam logic signed [W-1:0] c_NEG_PI    = -PI_Q;
    localparam logic signed [W-1:0] c_NEG_PI_M1 = -c_PI_M1;
    localparam logic signed [W:0]   c_PI_X      = {PI_Q[W-1], PI_Q};
    localparam logic signed [W:0]   c_NEG_PI_X  = -c_PI_X;
    localparam logic signed [W:0]   c_TWO_PI_X  = {TWO_PI_Q[W-1], TWO_PI_Q};

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic                 w_timeout_hit;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_inc;
    logic signed [W-1:0]  r_theta;
    logic signed [W-1:0]  r_omega;
    logic signed [W:0]    r_sum;
    logic signed [W-1:0]  w_init_clamp;
    logic signed [W-1:0]  w_inc_clamp;
    logic signed [W:0]    w_wrapped;
    logic                 r_sta_cos;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err_overrun;
    logic                 r_err_timeout;

    assign w_cnt_inc = r_cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // cos_done is tested before the watchdog so a coincident handshake wins
    always_comb begin
        w_state_next  = r_state;
        w_timeout_hit = 1'b0;
        case (r_state)
            c_IDLE:  if (step && !load) w_state_next = c_ACCUM;
            c_ACCUM: w_state_next = c_WRAP;
            c_WRAP:  w_state_next = c_ISSUE;
            c_ISSUE: w_state_next = c_WAIT;
            c_WAIT: begin
                if (cos_done) begin
                    w_state_next = c_DONE;
                end else if (w_cnt_inc == c_CNT_W'(TIMEOUT - 1)) begin
                    w_state_next  = c_IDLE;
                    w_timeout_hit = 1'b1;
                end
            end
            c_DONE:  w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_init_clamp = $signed(theta_init);
        if ($signed(theta_init) > c_PI_M1) begin
            w_init_clamp = c_PI_M1;
        end else if ($signed(theta_init) < c_NEG_PI) begin
            w_init_clamp = c_NEG_PI;
        end
    end

    // Increment is bounded below pi so a single 2*pi correction always suffices
    always_comb begin
        w_inc_clamp = r_omega;
        if (r_omega > c_PI_M1) begin
            w_inc_clamp = c_PI_M1;
        end else if (r_omega < c_NEG_PI_M1) begin
            w_inc_clamp = c_NEG_PI_M1;
        end
    end

    always_comb begin
        w_wrapped = r_sum;
        if (r_sum >= c_PI_X) begin
            w_wrapped = r_sum - c_TWO_PI_X;
        end else if (r_sum < c_NEG_PI_X) begin
            w_wrapped = r_sum + c_TWO_PI_X;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_theta       <= '0;
            r_omega       <= '0;
            r_sum         <= '0;
            r_cnt         <= '0;
            r_sta_cos     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err_overrun <= 1'b0;
            r_err_timeout <= 1'b0;
        end else begin
            r_sta_cos <= (w_state_next == c_ISSUE);
            r_done    <= (w_state_next == c_DONE);
            r_busy    <= (w_state_next != c_IDLE);

            if (r_state == c_IDLE) begin
                if (load) begin
                    r_theta <= w_init_clamp;
                end else if (step) begin
                    r_omega <= $signed(omega_dt);
                end
            end

            if (r_state == c_ACCUM) begin
                r_sum <= {r_theta[W-1], r_theta} + {w_inc_clamp[W-1], w_inc_clamp};
            end

            if (r_state == c_WRAP) begin
                r_theta <= w_wrapped[W-1:0];
            end

            if (r_state == c_ISSUE) begin
                r_cnt <= '0;
            end else if (r_state == c_WAIT) begin
                r_cnt <= w_cnt_inc;
            end

            r_err_overrun <= (r_err_overrun & ~clr_err) | (step & (r_state != c_IDLE));
            r_err_timeout <= (r_err_timeout & ~clr_err) | w_timeout_hit;
        end
    end

    assign theta       = r_theta;
    assign sta_cos     = r_sta_cos;
    assign busy        = r_busy;
    assign done_sig    = r_done;
    assign err_overrun = r_err_overrun;
    assign err_timeout = r_err_timeout;

endmodule
`default_nettype wire

// File: tb/tb_theta_phase_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_theta_phase_accumulator
//  Brief    : Directed bench for theta_phase_accumulator with a 36-cycle
//             cosine-stage model and an expected-theta scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_theta_phase_accumulator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        step = 1'b0;
    logic        load = 1'b0;
    logic [31:0] theta_init = '0;
    logic [31:0] omega_dt = '0;
    logic        clr_err = 1'b0;
    logic        cos_done = 1'b0;
    logic [31:0] theta;
    logic        sta_cos;
    logic        busy;
    logic        done_sig;
    logic        err_overrun;
    logic        err_timeout;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    bit          cos_en = 1'b1;
    int          cos_cd = 0;
    logic [31:0] sb[$];

    theta_phase_accumulator dut (
        .clk         (clk),
        .rst         (rst),
        .step        (step),
        .load        (load),
        .theta_init  (theta_init),
        .omega_dt    (omega_dt),
        .clr_err     (clr_err),
        .cos_done    (cos_done),
        .theta       (theta),
        .sta_cos     (sta_cos),
        .busy        (busy),
        .done_sig    (done_sig),
        .err_overrun (err_overrun),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Cosine stage: cos_done is high exactly 36 cycles after the sta_cos cycle
    always begin
        @(posedge clk);
        #1;
        cos_done = 1'b0;
        if (rst) begin
            cos_cd = 0;
        end else if (sta_cos && cos_en) begin
            cos_cd = 36;
        end else if (cos_cd > 0) begin
            cos_cd--;
            if (cos_cd == 0) cos_done = 1'b1;
        end
    end

    always begin
        @(posedge clk);
        #3;
        if (sta_cos) begin
            chk("sb_pending", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) chk("sb_theta", theta, sb.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load_theta(input logic [31:0] v, input logic [31:0] exp);
        load = 1'b1;
        theta_init = v;
        tick();
        load = 1'b0;
        chk("load_theta", theta, exp);
    endtask

    task automatic start_step(input logic [31:0] om, input logic [31:0] exp, output int n0);
        n0 = cyc;
        step = 1'b1;
        omega_dt = om;
        sb.push_back(exp);
        tick();
        step = 1'b0;
        chk("busy_n1", busy, 1);
        tick();
        tick();
        chk("sta_cos_n3", sta_cos, 1);
        chk("theta_n3", theta, exp);
    endtask

    task automatic finish_step(input int n0);
        int k = 0;
        while (!done_sig && k < 100) begin
            tick();
            k++;
        end
        chk("done_seen", done_sig, 1);
        chk("done_latency", 32'(cyc - n0), 32'd40);
        chk("busy_at_done", busy, 1);
        tick();
        chk("busy_after_done", busy, 0);
        chk("done_one_cycle", done_sig, 0);
    endtask

    initial begin
        int n0;
        int dn;
        repeat (3) tick();
        chk("rst_theta", theta, 0);
        chk("rst_sta_cos", sta_cos, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done_sig, 0);
        chk("rst_err_overrun", err_overrun, 0);
        chk("rst_err_timeout", err_timeout, 0);
        rst = 1'b0;
        tick();

        // Nominal 50 Hz step
        load_theta(32'd0, 32'd0);
        start_step(32'd4216574, 32'd4216574, n0);
        finish_step(n0);

        // Positive and negative wrap
        load_theta(32'd843313857, 32'd843313857);
        start_step(32'd4216574, -32'sd839099282, n0);
        finish_step(n0);
        load_theta(-32'sd843314857, -32'sd843314857);
        start_step(-32'sd4216574, 32'd839098282, n0);
        finish_step(n0);

        // Overrun: second step at N+10 leaves the first step intact
        load_theta(32'd0, 32'd0);
        start_step(32'd4216574, 32'd4216574, n0);
        repeat (7) tick();
        step = 1'b1;
        omega_dt = 32'd999;
        tick();
        step = 1'b0;
        chk("overrun_set", err_overrun, 1);
        finish_step(n0);
        chk("overrun_theta_kept", theta, 32'd4216574);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("overrun_cleared", err_overrun, 0);

        // Load and step together: load wins silently
        load = 1'b1;
        step = 1'b1;
        theta_init = 32'd1000;
        omega_dt = 32'd5;
        tick();
        load = 1'b0;
        step = 1'b0;
        chk("ldstep_theta", theta, 32'd1000);
        chk("ldstep_busy", busy, 0);
        chk("ldstep_no_err", err_overrun, 0);
        repeat (3) tick();
        chk("ldstep_no_start", busy, 0);

        // Watchdog timeout
        cos_en = 1'b0;
        start_step(32'd5, 32'd1005, n0);
        dn = 0;
        for (int i = 1; i <= 64; i++) begin
            tick();
            if (done_sig) dn++;
            if (i == 63) begin
                chk("to_busy_before", busy, 1);
                chk("to_err_before", err_timeout, 0);
            end
        end
        chk("to_err_set", err_timeout, 1);
        chk("to_busy_cleared", busy, 0);
        chk("to_no_done", 32'(dn), 32'd0);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("to_err_cleared", err_timeout, 0);
        cos_en = 1'b1;
        start_step(32'd5, 32'd1010, n0);
        finish_step(n0);
        chk("to_recovered", err_timeout, 0);

        // Clamp boundaries
        load_theta(32'h7FFF_FFFF, 32'd843314856);
        load_theta(32'h8000_0000, -32'sd843314857);
        load_theta(32'd0, 32'd0);
        start_step(32'h7FFF_FFFF, 32'd843314856, n0);
        finish_step(n0);

        // Reset during WAIT aborts the step
        load_theta(32'd0, 32'd0);
        start_step(32'd4216574, 32'd4216574, n0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_theta", theta, 0);
        chk("abort_busy", busy, 0);
        chk("abort_sta_cos", sta_cos, 0);
        chk("abort_done", done_sig, 0);
        chk("abort_errs", {30'd0, err_overrun, err_timeout}, 0);
        dn = 0;
        for (int i = 0; i < 45; i++) begin
            tick();
            if (done_sig || busy) dn++;
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
